// File: rtl/ring_pkg.sv
// Shared types, defaults and helpers for consumers of the one-hot ring counter.
package ring_pkg;

  typedef enum logic {ACQ, TRACK} ring_state_e;

  localparam int unsigned RING_N     = 5;
  localparam int unsigned RING_IDX_W = 3;
  localparam int unsigned RING_MAX_N = 16;

  // Rotate the low n bits of v left by one; bits at and above n come back as zero.
  function automatic logic [RING_MAX_N-1:0] rotl1(input logic [RING_MAX_N-1:0] v,
                                                  input int unsigned n);
    logic [RING_MAX_N-1:0] mask;
    logic [RING_MAX_N-1:0] r;
    mask = (RING_MAX_N'(1) << n) - RING_MAX_N'(1);
    r    = (v << 1) | (v >> (n - 1));
    return r & mask;
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// One-hot to binary encoder with a legality flag (exactly one bit set).
module ring_onehot_enc import ring_pkg::*; #(
  parameter int unsigned N     = RING_N,
  parameter int unsigned IDX_W = RING_IDX_W
) (
  input  logic [N-1:0]     ring_in,
  output logic [IDX_W-1:0] idx,
  output logic             legal
);

  logic [4:0] ones;

  // idx is only meaningful when legal; for illegal codes it is an OR of hot positions.
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (ring_in[i]) begin
        ones = ones + 5'd1;
        idx  = idx | IDX_W'(i);
      end
    end
    legal = (ones == 5'd1);
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// Checks legality and rotation of a one-hot ring, encodes phase, counts revolutions and errors.
// Optional RING_STALL_EN adds an adv input; adv=0 in TRACK expects the ring to hold.
module ring_phase_monitor import ring_pkg::*; #(
  parameter int unsigned N     = RING_N,
  parameter int unsigned IDX_W = RING_IDX_W,
  parameter int unsigned REV_W = 8,
  parameter int unsigned ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef RING_STALL_EN
  input  logic             adv,
`endif
  input  logic [N-1:0]     ring_in,
  input  logic             clr_err,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             wrap,
  output logic [REV_W-1:0] rev_cnt,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt
);

  ring_state_e      state_q, state_d;
  logic [N-1:0]     prev_q, prev_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             wrap_q, wrap_d;
  logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;
  logic             err_onehot_q, err_onehot_d;
  logic             err_seq_q, err_seq_d;
  logic             err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [IDX_W-1:0]      enc_idx;
  logic                  legal;
  logic                  advancing;
  logic                  match;
  logic [RING_MAX_N-1:0] exp_full;

  ring_onehot_enc #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_enc (
    .ring_in (ring_in),
    .idx     (enc_idx),
    .legal   (legal)
  );

`ifdef RING_STALL_EN
  assign advancing = adv;
`else
  assign advancing = 1'b1;
`endif

  // Compare in the package's full width so no rotation bits are left dangling.
  always_comb begin
    exp_full = advancing ? rotl1(RING_MAX_N'(prev_q), N) : RING_MAX_N'(prev_q);
    match    = (RING_MAX_N'(ring_in) == exp_full);
  end

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    idx_d        = idx_q;
    idx_valid_d  = 1'b0;
    wrap_d       = 1'b0;
    rev_cnt_d    = rev_cnt_q;
    err_onehot_d = 1'b0;
    err_seq_d    = 1'b0;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;

    case (state_q)
      ACQ: begin
        if (legal) begin
          prev_d      = ring_in;
          idx_d       = enc_idx;
          idx_valid_d = 1'b1;
          state_d     = TRACK;
        end else begin
          err_onehot_d = 1'b1;
        end
      end
      TRACK: begin
        if (!legal) begin
          err_onehot_d = 1'b1;
          state_d      = ACQ;
        end else begin
          // A legal but unexpected phase resynchronises rather than dropping lock.
          prev_d      = ring_in;
          idx_d       = enc_idx;
          idx_valid_d = 1'b1;
          if (!match) begin
            err_seq_d = 1'b1;
          end else if (advancing && prev_q[N-1] && ring_in[0]) begin
            wrap_d    = 1'b1;
            rev_cnt_d = rev_cnt_q + REV_W'(1);
          end
        end
      end
      default: state_d = ACQ;
    endcase

    // An error in the same cycle as clr_err wins and restarts the count at one.
    if (err_onehot_d || err_seq_d) begin
      err_sticky_d = 1'b1;
      if (clr_err) begin
        err_cnt_d = ERR_W'(1);
      end else if (err_cnt_q != {ERR_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end else if (clr_err) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACQ;
      prev_q       <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      wrap_q       <= 1'b0;
      rev_cnt_q    <= '0;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      idx_q        <= idx_d;
      idx_valid_q  <= idx_valid_d;
      wrap_q       <= wrap_d;
      rev_cnt_q    <= rev_cnt_d;
      err_onehot_q <= err_onehot_d;
      err_seq_q    <= err_seq_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign idx        = idx_q;
  assign idx_valid  = idx_valid_q;
  assign wrap       = wrap_q;
  assign rev_cnt    = rev_cnt_q;
  assign err_onehot = err_onehot_q;
  assign err_seq    = err_seq_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor: phase-level reference model, directed and random stimulus.
module tb_ring_phase_monitor;

  localparam int N     = 5;
  localparam int IDX_W = 3;
  localparam int REV_W = 8;
  localparam int ERR_W = 4;
  localparam int REV_MOD = 256;
  localparam int ERR_MAX = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             adv;
  logic [N-1:0]     ring_in;
  logic             clr_err;
  logic [IDX_W-1:0] idx;
  logic             idx_valid;
  logic             wrap;
  logic [REV_W-1:0] rev_cnt;
  logic             err_onehot;
  logic             err_seq;
  logic             err_sticky;
  logic [ERR_W-1:0] err_cnt;

  always #5 clk = ~clk;

  ring_phase_monitor #(
    .N     (N),
    .IDX_W (IDX_W),
    .REV_W (REV_W),
    .ERR_W (ERR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef RING_STALL_EN
    .adv        (adv),
`endif
    .ring_in    (ring_in),
    .clr_err    (clr_err),
    .idx        (idx),
    .idx_valid  (idx_valid),
    .wrap       (wrap),
    .rev_cnt    (rev_cnt),
    .err_onehot (err_onehot),
    .err_seq    (err_seq),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  typedef struct {
    int idx; int valid; int wrap; int rev; int eo; int es; int sticky; int cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int dut_wraps = 0;

  // Reference model: phase as an integer position plus a lock flag.
  int m_locked = 0;
  int m_p = 0;
  int m_idx = 0;
  int m_rev = 0;
  int m_cnt = 0;
  int m_sticky = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pos_of(input logic [N-1:0] v);
    int p = 0;
    for (int i = 0; i < N; i++) if (v[i]) p = i;
    return p;
  endfunction

  task automatic model_push();
    exp_t e;
    int ones, p, nxt;
    e = '{0, 0, 0, 0, 0, 0, 0, 0};
    if (rst) begin
      m_locked = 0; m_p = 0; m_idx = 0; m_rev = 0; m_cnt = 0; m_sticky = 0;
    end else begin
      ones = $countones(ring_in);
      p    = pos_of(ring_in);
      if (ones != 1) begin
        e.eo = 1;
        m_locked = 0;
      end else if (m_locked == 0) begin
        m_locked = 1; m_p = p; m_idx = p; e.valid = 1;
      end else begin
        nxt = (m_p + 1) % N;
`ifdef RING_STALL_EN
        if (!adv) nxt = m_p;
`endif
        if (p != nxt) e.es = 1;
        else if (nxt != m_p && m_p == N - 1) begin
          e.wrap = 1;
          m_rev = (m_rev + 1) % REV_MOD;
        end
        m_p = p; m_idx = p; e.valid = 1;
      end
      if (e.eo != 0 || e.es != 0) begin
        m_sticky = 1;
        m_cnt = clr_err ? 1 : (m_cnt < ERR_MAX ? m_cnt + 1 : ERR_MAX);
      end else if (clr_err) begin
        m_sticky = 0; m_cnt = 0;
      end
    end
    e.idx = m_idx; e.rev = m_rev; e.sticky = m_sticky; e.cnt = m_cnt;
    sbq.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge after the DUT sampled.
  task automatic step(input logic [N-1:0] r, input logic c, input logic rs);
    ring_in = r; clr_err = c; rst = rs;
    model_push();
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      check("idx",        32'(idx),        32'(mon_e.idx));
      check("idx_valid",  32'(idx_valid),  32'(mon_e.valid));
      check("wrap",       32'(wrap),       32'(mon_e.wrap));
      check("rev_cnt",    32'(rev_cnt),    32'(mon_e.rev));
      check("err_onehot", 32'(err_onehot), 32'(mon_e.eo));
      check("err_seq",    32'(err_seq),    32'(mon_e.es));
      check("err_sticky", 32'(err_sticky), 32'(mon_e.sticky));
      check("err_cnt",    32'(err_cnt),    32'(mon_e.cnt));
      if (wrap) dut_wraps++;
    end
  end

  logic [N-1:0] cur;
  logic [N-1:0] rnd;
  int w0;
  int sel;

  initial begin
    rst = 1'b1; ring_in = '0; clr_err = 1'b0; adv = 1'b1;
    @(negedge clk);

    // Reset then one clean revolution.
    step(5'b00000, 1'b0, 1'b1);
    check("reset_valid", 32'(idx_valid), 32'd0);
    check("reset_cnt", 32'(err_cnt), 32'd0);
    w0 = dut_wraps;
    step(5'b00001, 0, 0); step(5'b00010, 0, 0); step(5'b00100, 0, 0);
    step(5'b01000, 0, 0); step(5'b10000, 0, 0); step(5'b00001, 0, 0);
    check("rev1_cnt", 32'(rev_cnt), 32'd1);
    check("rev1_wraps", 32'(dut_wraps - w0), 32'd1);

    // 300 clean revolutions.
    step(5'b00000, 1'b0, 1'b1);
    w0 = dut_wraps;
    step(5'b00001, 0, 0);
    for (int r = 0; r < 300; r++) begin
      step(5'b00010, 0, 0); step(5'b00100, 0, 0); step(5'b01000, 0, 0);
      step(5'b10000, 0, 0); step(5'b00001, 0, 0);
    end
    check("rev300_cnt", 32'(rev_cnt), 32'd44);
    check("rev300_wraps", 32'(dut_wraps - w0), 32'd300);

    // Illegal code in TRACK, then reacquire without a sequence error.
    step(5'b00011, 0, 0);
    check("inj_onehot", 32'(err_onehot), 32'd1);
    check("inj_cnt", 32'(err_cnt), 32'd1);
    step(5'b00100, 0, 0);
    check("reacq_idx", 32'(idx), 32'd2);
    check("reacq_seq", 32'(err_seq), 32'd0);

    // Skip 00010 -> 01000.
    step(5'b01000, 0, 0); step(5'b10000, 0, 0); step(5'b00001, 0, 0);
    step(5'b00010, 0, 0); step(5'b01000, 0, 0);
    check("skip_seq", 32'(err_seq), 32'd1);
    check("skip_idx", 32'(idx), 32'd3);
    check("skip_valid", 32'(idx_valid), 32'd1);
    step(5'b10000, 0, 0);
    check("skip_next_seq", 32'(err_seq), 32'd0);

    // Saturation and clear interactions.
    for (int i = 0; i < 20; i++) step(5'b00000, 0, 0);
    check("sat_cnt", 32'(err_cnt), 32'd15);
    step(5'b00001, 1, 0);
    check("clr_cnt", 32'(err_cnt), 32'd0);
    check("clr_sticky", 32'(err_sticky), 32'd0);
    step(5'b00011, 1, 0);
    check("clr_err_cnt", 32'(err_cnt), 32'd1);
    check("clr_err_sticky", 32'(err_sticky), 32'd1);

    // Reset mid-revolution.
    step(5'b00001, 0, 0); step(5'b00010, 0, 0); step(5'b00100, 0, 0);
    step(5'b01000, 0, 1);
    check("midrst_valid", 32'(idx_valid), 32'd0);
    check("midrst_sticky", 32'(err_sticky), 32'd0);
    step(5'b00001, 0, 0);
    check("midrst_acq_valid", 32'(idx_valid), 32'd1);
    step(5'b00010, 0, 0); step(5'b00100, 0, 0);
`ifdef RING_STALL_EN
    adv = 1'b0;
    step(5'b00100, 0, 0);
    check("stall_seq", 32'(err_seq), 32'd0);
    check("stall_idx", 32'(idx), 32'd2);
    adv = 1'b1;
`endif

    // Randomised traffic.
    cur = 5'b00100;
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 99));
`ifdef RING_STALL_EN
      adv = ($urandom_range(0, 3) != 0);
`endif
      if (sel < 80) begin
        if (adv) cur = {cur[N-2:0], cur[N-1]};
        step(cur, ($urandom_range(0, 19) == 0), 0);
      end else if (sel < 88) begin
        cur = N'(1) << $urandom_range(0, N - 1);
        step(cur, 0, 0);
      end else if (sel < 96) begin
        do rnd = N'($urandom_range(0, 31)); while ($countones(rnd) == 1);
        step(rnd, ($urandom_range(0, 3) == 0), 0);
      end else begin
        step(5'b00000, 0, 1);
        cur = 5'b10000;
      end
    end

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    check("drain", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
